// File: rtl/gate_tt_sequencer.sv
// On-chip truth-table sequencer for one 2-input gate: walks {A,B} in Gray order and scores each sample.
// Optional macro GATE_TT_SEQ_LOOP_EN: a run ending with start high restarts at once (soak mode).
`timescale 1ns/1ps
module gate_tt_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       O,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_vec,
    output logic [3:0] captured
);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0] CNT_LOAD = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] step, step_inc, vec;
    logic [7:0] cnt;
    logic       mismatch, restart;

    // Step -> {A,B}: 0->00, 1->10, 2->11, 3->01, one input toggles per step
    function automatic logic [1:0] gray_vec(input logic [1:0] s);
        return {s[0] ^ s[1], s[1]};
    endfunction

`ifdef GATE_TT_SEQ_LOOP_EN
    assign restart = start;
`else
    assign restart = 1'b0;
`endif

    assign vec      = {A, B};
    assign step_inc = step + 2'd1;
    assign mismatch = (O != EXPECTED[vec]);
    assign busy     = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY:   state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            SETTLE:  if (cnt == 8'd0) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (step == 2'd3) ? DONE : APPLY;
            DONE:    state_nxt = restart ? APPLY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            cnt       <= 8'd0;
            A         <= 1'b0;
            B         <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 2'd0;
            captured  <= 4'b0000;
        end else begin
            state <= state_nxt;
            // done is registered off DONE so it lines up with the freshly written pass
            done  <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        step      <= 2'd0;
                        A         <= 1'b0;
                        B         <= 1'b0;
                        err_count <= 3'd0;
                        fail_vec  <= 2'd0;
                        captured  <= 4'b0000;
                        pass      <= 1'b0;
                    end
                end
                APPLY:  cnt <= CNT_LOAD;
                SETTLE: if (cnt != 8'd0) cnt <= cnt - 8'd1;
                SAMPLE: begin
                    captured[vec] <= O;
                    if (mismatch && err_count != 3'd4) begin
                        err_count <= err_count + 3'd1;
                        if (err_count == 3'd0) fail_vec <= vec;
                    end
                    if (step != 2'd3) begin
                        step   <= step_inc;
                        {A, B} <= gray_vec(step_inc);
                    end
                end
                DONE: begin
                    pass <= (err_count == 3'd0);
                    A    <= 1'b0;
                    B    <= 1'b0;
                    if (restart) begin
                        step      <= 2'd0;
                        err_count <= 3'd0;
                        fail_vec  <= 2'd0;
                        captured  <= 4'b0000;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Scoreboard bench: default-settle instance exercises results/reset, zero-settle instance exercises run chaining.
`timescale 1ns/1ps
module tb_gate_tt_sequencer;

    logic clk = 1'b0;
    logic rst, start0, start1;
    logic a0, b0, o0, busy0, done0, pass0;
    logic a1, b1, o1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [1:0] fv0, fv1;
    logic [3:0] cap0, cap1;
    int mode;  // 0 ideal NOR, 1 stuck-at-0, 2 stuck-at-1

    typedef struct {
        logic [3:0] cap;
        logic [2:0] err;
        logic [1:0] fv;
        logic       pass;
        logic [7:0] seq;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   sb1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign o0 = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ~(a0 | b0);
    assign o1 = ~(a1 | b1);

    gate_tt_sequencer u0 (
        .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0), .O(o0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_vec(fv0), .captured(cap0)
    );

    gate_tt_sequencer #(.SETTLE_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .O(o1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fv1), .captured(cap1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One run on u0; expectation goes in the scoreboard now, is popped when done fires
    task automatic run0(input int m, input int repulse, input exp_t e);
        logic [7:0] seq;
        logic [1:0] last;
        int nseq, ndone, lat;
        exp_t x;
        seq = 8'h00; last = 2'b00; nseq = 0; ndone = 0; lat = -1;
        mode = m;
        sb.push_back(e);
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        for (int n = 0; n <= 45; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
                start0 = (n == repulse);
            end
            if (busy0 && (nseq == 0 || {a0, b0} != last)) begin
                seq  = {seq[5:0], a0, b0};
                last = {a0, b0};
                nseq++;
            end
            if (done0) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    if (sb.size() == 0) begin
                        chk("sb_empty", 32'd0, 32'd1);
                    end else begin
                        x = sb.pop_front();
                        chk("latency",  lat,   x.lat);
                        chk("captured", cap0,  x.cap);
                        chk("err_count", err0, x.err);
                        chk("fail_vec", fv0,   x.fv);
                        chk("pass",     pass0, x.pass);
                        chk("ab_seq",   seq,   x.seq);
                        chk("ab_steps", nseq,  4);
                    end
                end
            end
        end
        start0 = 1'b0;
        chk("done_count", ndone, 1);
    endtask

    initial begin
        exp_t e;
        int ndone;
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int ndone;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", a0, 0);       chk("rst_b", b0, 0);
        chk("rst_busy", busy0, 0); chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0); chk("rst_err", err0, 0);
        chk("rst_fv", fv0, 0);     chk("rst_cap", cap0, 0);
        rst = 1'b0;

        // ideal NOR
        e = '{cap: 4'b0001, err: 3'd0, fv: 2'b00, pass: 1'b1, seq: 8'h2D, lat: 17};
        run0(0, 0, e);
        // stuck-at-0: only vector 00 differs
        e = '{cap: 4'b0000, err: 3'd1, fv: 2'b00, pass: 1'b0, seq: 8'h2D, lat: 17};
        run0(1, 0, e);
        // stuck-at-1: first failure is vector 10
        e = '{cap: 4'b1111, err: 3'd3, fv: 2'b10, pass: 1'b0, seq: 8'h2D, lat: 17};
        run0(2, 0, e);
        // start re-pulsed mid-run must be ignored
        e = '{cap: 4'b0001, err: 3'd0, fv: 2'b00, pass: 1'b1, seq: 8'h2D, lat: 17};
        run0(0, 5, e);

        // reset during SETTLE of vector 11 (stuck-at-1 so partial results are non-zero)
        mode = 2;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_ab", {a0, b0}, 2'b11);
        chk("pre_rst_err", err0, 1);
        chk("pre_rst_busy", busy0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ab", {a0, b0}, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_err", err0, 0);
        chk("mid_rst_cap", cap0, 0);
        ndone = 0;
        for (int n = 0; n < 30; n++) begin
            if (done0) ndone++;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_done", ndone, 0);

        // zero-settle instance with start held: run-to-run spacing shows chaining
`ifdef GATE_TT_SEQ_LOOP_EN
        sb1.push_back(9); sb1.push_back(18); sb1.push_back(27);
`else
        sb1.push_back(9); sb1.push_back(19); sb1.push_back(29);
`endif
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done1) begin
                if (sb1.size() == 0) begin
                    chk("loop_extra_done", n, 0);
                end else begin
                    chk("loop_done_edge", n, sb1.pop_front());
                    chk("loop_pass", pass1, 1);
                end
            end
        end
        chk("loop_missing_done", sb1.size(), 0);
        start1 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("loop_idle_busy", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
